// File: rtl/param_shift_engine.sv
// param_shift_engine: multi-cycle SLL/SRL/SRA/ROR of a WIDTH-bit register, at most STEP bits per clock
// ports: clk, rst_n (async active-low), load/data (parallel load, top priority),
//        start/op/amount (begin an operation from IDLE), busy, done (1-cycle pulse), q
module param_shift_engine #(
  parameter int WIDTH = 64,
  parameter int STEP = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   data,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] amount,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W+1)'(WIDTH);
  state_t state, state_n;
  logic [1:0] op_r, op_n;
  logic [SHAMT_W:0] rem, rem_n, s, rs;
  logic [WIDTH-1:0] q_n, sra, sh;
  logic busy_n, done_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_r <= '0;
      rem <= '0;
      q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      op_r <= op_n;
      rem <= rem_n;
      q <= q_n;
      busy <= busy_n;
      done <= done_n;
    end
  // sra kept in its own statement so the shift stays signed (a mixed ternary would make it logical)
  always_comb begin
    s = rem > STEP_L ? STEP_L : rem;
    rs = WIDTH_L - s;
    sra = $signed(q) >>> s;
    sh = op_r == 2'd0 ? q << s : op_r == 2'd1 ? q >> s : op_r == 2'd2 ? sra : (q >> s) | (q << rs);
    state_n = state;
    op_n = op_r;
    rem_n = rem;
    q_n = q;
    busy_n = busy;
    done_n = 1'b0;
    if (load) begin
      q_n = data;
      state_n = IDLE;
      rem_n = '0;
      busy_n = 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        if (amount == '0) begin
          done_n = 1'b1;
        end else begin
          op_n = op;
          rem_n = {1'b0, amount};
          busy_n = 1'b1;
          state_n = SHIFT;
        end
      end
    end else begin
      q_n = sh;
      rem_n = rem - s;
      if (rem == s) begin
        busy_n = 1'b0;
        done_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_param_shift_engine.sv
// tb_param_shift_engine: randomized and directed checks of param_shift_engine against a bit-level model
module tb_param_shift_engine;
  logic clk = 0, rst_n = 0, load = 0, start = 0, busy, done;
  logic [63:0] data = 0, q;
  logic [1:0] op = 0;
  logic [5:0] amount = 0;
  int total = 0, bad = 0;

  param_shift_engine #(.WIDTH(64), .STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .start(start),
    .op(op), .amount(amount), .busy(busy), .done(done), .q(q)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(logic [63:0] d, logic [1:0] o, int a);
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      case (o)
        2'd0: r[i] = (i >= a) ? d[i-a] : 1'b0;
        2'd1: r[i] = (i + a < 64) ? d[i+a] : 1'b0;
        2'd2: r[i] = (i + a < 64) ? d[i+a] : d[63];
        default: r[i] = d[(i+a)%64];
      endcase
    return r;
  endfunction

  task automatic run_op(input logic [63:0] d, input logic [1:0] o, input int a, input bit poke);
    logic [63:0] exp;
    int ecyc, cnt;
    exp = model(d, o, a);
    ecyc = (a + 7) / 8;
    load = 1; data = d; step(); load = 0;
    start = 1; op = o; amount = a[5:0]; step(); start = 0;
    if (a == 0) begin
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_amt done=%b busy=%b want done=1 busy=0", done, busy); end
      total++; if (q !== exp) begin bad++; $display("FAIL zero_q got=%h want=%h", q, exp); end
      step();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", done); end
      return;
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (poke && cnt == 1) begin start = 1; op = 2'($urandom); amount = 6'($urandom); end
      else start = 0;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL done_early cyc=%0d got=%b want=0", cnt, done); end
      step();
    end
    start = 0;
    total++; if (cnt != ecyc) begin bad++; $display("FAIL busy_cycles op=%0d amt=%0d got=%0d want=%0d", o, a, cnt, ecyc); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_pulse op=%0d amt=%0d got=%b want=1", o, a, done); end
    total++; if (q !== exp) begin bad++; $display("FAIL result op=%0d amt=%0d d=%h got=%h want=%h", o, a, d, q, exp); end
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL after_done done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_reset();
    #1;
    total++; if (q !== 64'd0) begin bad++; $display("FAIL reset_q got=%h want=0", q); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_directed();
    run_op(64'h8000_0000_0000_0010, 2'd2, 4, 0);
    total++; if (q !== 64'hF800_0000_0000_0001) begin bad++; $display("FAIL sra4 got=%h want=f800000000000001", q); end
    run_op(64'h1, 2'd0, 20, 0);
    total++; if (q !== 64'h0000_0000_0010_0000) begin bad++; $display("FAIL sll20 got=%h want=100000", q); end
    run_op(64'h1, 2'd3, 63, 0);
    total++; if (q !== 64'h2) begin bad++; $display("FAIL ror63 got=%h want=2", q); end
    for (int o = 0; o < 4; o++) begin
      run_op(64'h8123_4567_89AB_CDEF, 2'(o), 1, 0);
      run_op(64'h8123_4567_89AB_CDEF, 2'(o), 8, 0);
      run_op(64'h8123_4567_89AB_CDEF, 2'(o), 9, 0);
      run_op(64'h8123_4567_89AB_CDEF, 2'(o), 63, 0);
    end
  endtask

  task automatic test_zero();
    run_op(64'hDEAD_BEEF_0123_4567, 2'd1, 0, 0);
    run_op(64'hDEAD_BEEF_0123_4567, 2'd3, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_op(64'hFEDC_BA98_7654_3210, 2'd2, 37, 1);
    run_op(64'h0F0F_0000_1234_5678, 2'd3, 9, 1);
  endtask

  task automatic test_abort();
    int cnt;
    load = 1; data = 64'hFFFF_0000_0000_0000; step(); load = 0;
    start = 1; op = 2'd1; amount = 6'd40; step(); start = 0;
    cnt = 1;
    step();
    load = 1; data = 64'hAAAA; step(); load = 0;
    total++; if (q !== 64'hAAAA) begin bad++; $display("FAIL abort_q got=%h want=aaaa", q); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_flags busy=%b done=%b want 0 0", busy, done); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (done !== 1'b0 || busy !== 1'b0 || q !== 64'hAAAA) begin bad++; $display("FAIL abort_idle busy=%b done=%b q=%h", busy, done, q); end
    end
    cnt = cnt + 0;
  endtask

  task automatic test_async_reset();
    load = 1; data = 64'h1234_5678_9ABC_DEF0; step(); load = 0;
    start = 1; op = 2'd3; amount = 6'd63; step(); start = 0;
    step(); step();
    #2 rst_n = 0;
    #1;
    total++; if (q !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL async_reset q=%h busy=%b done=%b want 0 0 0", q, busy, done); end
    @(negedge clk); rst_n = 1;
    step();
    total++; if (busy !== 1'b0 || q !== 64'd0) begin bad++; $display("FAIL post_reset busy=%b q=%h", busy, q); end
    run_op(64'hC000_0000_0000_0003, 2'd2, 17, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_op({$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 63), bit'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
